// File: rtl/core_ctrl_if.sv
`default_nettype none
// ==========================================================================
// core_ctrl_if : per-core awaken/pause/memory-port bundle to the controller
// Revision     : 1.0
// ==========================================================================
interface core_ctrl_if #(
  parameter int NCORES = 4
);
  logic [19*NCORES-1:0] pc_out_in;
  logic [4*NCORES-1:0]  pause_resume_in;
  logic [NCORES-1:0]    ld_req;
  logic [NCORES-1:0]    st_req;
  logic [NCORES-1:0]    halt_in;
  logic [NCORES-1:0]    awake_in;
  logic [17*NCORES-1:0] pc_passed;
  logic [3*NCORES-1:0]  stall_num;
  logic [NCORES-1:0]    ld_grant;
  logic [NCORES-1:0]    st_grant;
  logic                 all_halted;
  logic [31:0]          conflict_count;

  modport master (
    output pc_out_in, pause_resume_in, ld_req, st_req, halt_in, awake_in,
    input  pc_passed, stall_num, ld_grant, st_grant, all_halted, conflict_count
  );

  modport slave (
    input  pc_out_in, pause_resume_in, ld_req, st_req, halt_in, awake_in,
    output pc_passed, stall_num, ld_grant, st_grant, all_halted, conflict_count
  );
endinterface
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// ==========================================================================
// core_ctrl : multicore boot, awaken, pause/resume and shared-port arbiter
//             optional stats counter under CORE_CTRL_STATS_EN
// Revision  : 1.0
// ==========================================================================
module core_ctrl #(
  parameter int          NCORES  = 4,
  parameter logic [15:0] BOOT_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  core_ctrl_if.slave bus
);

  logic              av_vld [NCORES];
  logic [1:0]        av_tgt [NCORES];
  logic [15:0]       av_pc  [NCORES];
  logic              pr_vld [NCORES];
  logic              pr_res [NCORES];
  logic [1:0]        pr_tgt [NCORES];

  generate
    for (genvar g = 0; g < NCORES; g++) begin : g_unpack
      assign av_vld[g] = bus.pc_out_in[19*g+18];
      assign av_tgt[g] = bus.pc_out_in[19*g+16 +: 2];
      assign av_pc[g]  = bus.pc_out_in[19*g +: 16];
      assign pr_vld[g] = bus.pause_resume_in[4*g+3];
      assign pr_res[g] = bus.pause_resume_in[4*g+2];
      assign pr_tgt[g] = bus.pause_resume_in[4*g +: 2];
    end
  endgenerate

  logic [17*NCORES-1:0] pc_passed_q, pc_passed_d;
  logic [NCORES-1:0]    paused_q, paused_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic                 boot_pending_q, boot_pending_d;
  logic                 all_halted_q, all_halted_d;

  logic [1:0]           order   [NCORES];
  logic [2:0]           code    [NCORES];
  logic [15:0]          wake_pc [NCORES];
  logic [2:0]           ord_sum;
  logic [1:0]           src;
  logic                 ld_found, st_found, tgt_ok;
  logic [NCORES-1:0]    ld_gnt, st_gnt, lose, wake_vld, taken, set_req, clr_req;
  logic [3*NCORES-1:0]  stall_w;

  always_comb begin
    ld_found       = 1'b0;
    st_found       = 1'b0;
    tgt_ok         = 1'b0;
    src            = 2'd0;
    ord_sum        = 3'd0;
    ld_gnt         = '0;
    st_gnt         = '0;
    lose           = '0;
    wake_vld       = '0;
    taken          = '0;
    set_req        = '0;
    clr_req        = '0;
    stall_w        = '0;
    pc_passed_d    = '0;
    paused_d       = paused_q;
    boot_pending_d = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    all_halted_d   = all_halted_q;

    for (int k = 0; k < NCORES; k++) begin
      ord_sum = {1'b0, rr_ptr_q} + 3'(k);
      if (ord_sum >= 3'(NCORES)) ord_sum = ord_sum - 3'(NCORES);
      order[k]   = ord_sum[1:0];
      code[k]    = 3'd0;
      wake_pc[k] = 16'h0000;
    end

    // Walk sources in round-robin priority; first claimant of each resource wins.
    for (int k = 0; k < NCORES; k++) begin
      src = order[k];
      if (bus.ld_req[src]) begin
        if (!ld_found) begin
          ld_found    = 1'b1;
          ld_gnt[src] = 1'b1;
        end else begin
          lose[src] = 1'b1;
          code[src] = 3'd4;
        end
      end
      if (bus.st_req[src]) begin
        if (!st_found) begin
          st_found    = 1'b1;
          st_gnt[src] = 1'b1;
        end else begin
          lose[src] = 1'b1;
          code[src] = 3'd6;
        end
      end
      tgt_ok = ({1'b0, av_tgt[src]} < 3'(NCORES));
      if (av_vld[src] && tgt_ok) begin
        if ((boot_pending_q && av_tgt[src] == 2'd0) || taken[av_tgt[src]]) begin
          lose[src] = 1'b1;
          code[src] = 3'd6;
        end else begin
          taken[av_tgt[src]]    = 1'b1;
          wake_vld[av_tgt[src]] = 1'b1;
          wake_pc[av_tgt[src]]  = av_pc[src];
        end
      end
    end

    for (int i = 0; i < NCORES; i++) begin
      if (pr_vld[i] && ({1'b0, pr_tgt[i]} < 3'(NCORES))) begin
        if (pr_res[i]) clr_req[pr_tgt[i]] = 1'b1;
        else           set_req[pr_tgt[i]] = 1'b1;
      end
    end

    // Awaken beats resume, which beats pause.
    for (int i = 0; i < NCORES; i++) begin
      if (paused_q[i]) code[i] = 3'd7;
      stall_w[3*i +: 3] = code[i];
      if (wake_vld[i] || clr_req[i]) paused_d[i] = 1'b0;
      else if (set_req[i])           paused_d[i] = 1'b1;
      if (wake_vld[i]) pc_passed_d[17*i +: 17] = {1'b1, wake_pc[i]};
    end

    if (boot_pending_q) pc_passed_d[16:0] = {1'b1, BOOT_PC};

    if (|lose) rr_ptr_d = (rr_ptr_q == 2'(NCORES-1)) ? 2'd0 : rr_ptr_q + 2'd1;

    if (|bus.awake_in) all_halted_d = &(~bus.awake_in | bus.halt_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_passed_q    <= '0;
      paused_q       <= '0;
      rr_ptr_q       <= 2'd0;
      boot_pending_q <= 1'b1;
      all_halted_q   <= 1'b0;
    end else begin
      pc_passed_q    <= pc_passed_d;
      paused_q       <= paused_d;
      rr_ptr_q       <= rr_ptr_d;
      boot_pending_q <= boot_pending_d;
      all_halted_q   <= all_halted_d;
    end
  end

  assign bus.pc_passed  = pc_passed_q;
  assign bus.stall_num  = stall_w;
  assign bus.ld_grant   = ld_gnt;
  assign bus.st_grant   = st_gnt;
  assign bus.all_halted = all_halted_q;

`ifdef CORE_CTRL_STATS_EN
  logic [31:0] conflict_count_q, conflict_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q;
    for (int i = 0; i < NCORES; i++) begin
      conflict_count_d = conflict_count_d + 32'(lose[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) conflict_count_q <= 32'h0;
    else       conflict_count_q <= conflict_count_d;
  end

  assign bus.conflict_count = conflict_count_q;
`else
  assign bus.conflict_count = 32'h0;
`endif

endmodule
`default_nettype wire
